// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Stage 1 registers propagate/generate terms; stage 2 resolves carries and registers sum and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             zero_out
);

  localparam int NGROUP = WIDTH / GROUP;

  logic             s1_valid_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] g_r;
  logic             cin_r;

  logic             out_adv_s;
  logic             s1_adv_s;
  logic             accept_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             zero_s;

  // Handshake: no skid buffer, so ready_out looks straight through to ready_in.
  always_comb begin
    out_adv_s = !valid_out || ready_in;
    s1_adv_s  = s1_valid_r && out_adv_s;
    ready_out = !s1_valid_r || s1_adv_s;
    accept_s  = valid_in && ready_out;
  end

  // Two-level look-ahead: group PG/GG feed the group carry-ins, then carries ripple inside each group.
  always_comb begin : carry_tree
    logic [NGROUP-1:0] pg_v;
    logic [NGROUP-1:0] gg_v;
    logic [NGROUP:0]   gc_v;
    logic [WIDTH:0]    cv;
    pg_v = {NGROUP{1'b0}};
    gg_v = {NGROUP{1'b0}};
    gc_v = {(NGROUP+1){1'b0}};
    cv   = {(WIDTH+1){1'b0}};
    for (int j = 0; j < NGROUP; j++) begin
      pg_v[j] = 1'b1;
      gg_v[j] = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        pg_v[j] = pg_v[j] & p_r[j*GROUP+i];
        gg_v[j] = g_r[j*GROUP+i] | (p_r[j*GROUP+i] & gg_v[j]);
      end
    end
    gc_v[0] = cin_r;
    for (int j = 0; j < NGROUP; j++) begin
      gc_v[j+1] = gg_v[j] | (pg_v[j] & gc_v[j]);
    end
    // Group boundaries take the look-ahead carry rather than the in-group ripple.
    for (int j = 0; j < NGROUP; j++) begin
      cv[j*GROUP] = gc_v[j];
      for (int i = 0; i < GROUP - 1; i++) begin
        cv[j*GROUP+i+1] = g_r[j*GROUP+i] | (p_r[j*GROUP+i] & cv[j*GROUP+i]);
      end
    end
    cv[WIDTH] = gc_v[NGROUP];
    sum_s  = p_r ^ cv[WIDTH-1:0];
    cout_s = cv[WIDTH];
    ovf_s  = cv[WIDTH] ^ cv[WIDTH-1];
    zero_s = (sum_s == {WIDTH{1'b0}});
  end

  // Stage 1: capture propagate/generate and carry-in on accept.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_r <= 1'b0;
      p_r        <= {WIDTH{1'b0}};
      g_r        <= {WIDTH{1'b0}};
      cin_r      <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      p_r        <= a_in ^ b_in;
      g_r        <= a_in & b_in;
      cin_r      <= c_in;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: output slot; a bubble clears valid_out only when the slot drains.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      sum_out   <= {WIDTH{1'b0}};
      c_out     <= 1'b0;
      ovf_out   <= 1'b0;
      zero_out  <= 1'b0;
    end else if (out_adv_s) begin
      valid_out <= s1_valid_r;
      if (s1_valid_r) begin
        sum_out  <= sum_s;
        c_out    <= cout_s;
        ovf_out  <= ovf_s;
        zero_out <= zero_s;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder: flags, streaming, backpressure, async reset.
module tb_pipelined_cla_adder;

  logic        clk_in;
  logic        rst_n_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        c_in;
  logic        valid_out;
  logic        ready_in;
  logic [15:0] sum_out;
  logic        c_out;
  logic        ovf_out;
  logic        zero_out;

  int n_tests;
  int n_fail;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .sum_out  (sum_out),
    .c_out    (c_out),
    .ovf_out  (ovf_out),
    .zero_out (zero_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Output bundle compared as {valid, sum, c, ovf, zero}.
  function automatic logic [19:0] obs();
    return {valid_out, sum_out, c_out, ovf_out, zero_out};
  endfunction

  task automatic test_reset();
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    a_in = 16'h0000; b_in = 16'h0000; c_in = 1'b0;
    #3;
    n_tests++;
    if (obs() !== 20'h00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), 20'h00000);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", ready_out);
    end
    @(negedge clk_in);
  endtask

  // One isolated op: check not-yet-valid after 1 cycle, result after 2, empty after 3.
  task automatic test_single(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic [15:0] es, input logic ec,
                             input logic eo, input logic ez);
    ready_in = 1'b1;
    valid_in = 1'b1; a_in = a; b_in = b; c_in = ci;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got %b expected 1", name, ready_out);
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: valid_out %b expected 0", name, valid_out);
    end
    @(negedge clk_in);
    n_tests++;
    if (obs() !== {1'b1, es, ec, eo, ez}) begin
      n_fail++;
      $display("FAIL %s_result: got %h expected %h", name, obs(), {1'b1, es, ec, eo, ez});
    end
    @(negedge clk_in);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: valid_out %b expected 0", name, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'hAAAA, 16'h1000, 16'hFFFE, 16'h4000, 16'hC000};
    logic [15:0] vb [8] = '{16'h0002, 16'h0001, 16'hF0F0, 16'h5555, 16'h2000, 16'h0003, 16'h4000, 16'h4000};
    logic        vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] es [8] = '{16'h0003, 16'h0100, 16'h0000, 16'hFFFF, 16'h3001, 16'h0001, 16'h8000, 16'h0000};
    logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ready_in = 1'b1;
    for (int t = 0; t < 11; t++) begin
      if (t >= 2 && t < 10) begin
        n_tests++;
        if ({valid_out, sum_out, c_out} !== {1'b1, es[t-2], ec[t-2]}) begin
          n_fail++;
          $display("FAIL b2b_op%0d: got v=%b s=%h c=%b expected v=1 s=%h c=%b",
                   t-2, valid_out, sum_out, c_out, es[t-2], ec[t-2]);
        end
      end else begin
        n_tests++;
        if (valid_out !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle_t%0d: valid_out %b expected 0", t, valid_out);
        end
      end
      if (t < 8) begin
        valid_in = 1'b1; a_in = va[t]; b_in = vb[t]; c_in = vc[t];
        #1;
        n_tests++;
        if (ready_out !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_t%0d: got %b expected 1", t, ready_out);
        end
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    valid_in = 1'b1; a_in = 16'h0010; b_in = 16'h0020; c_in = 1'b0;
    @(negedge clk_in);
    valid_in = 1'b1; a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b1;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_accept: ready_out %b expected 1", ready_out);
    end
    @(negedge clk_in);
    valid_in = 1'b1; a_in = 16'hFFFF; b_in = 16'h0000; c_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if ({ready_out, obs()} !== {1'b0, 1'b1, 16'h0030, 3'b000}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got rdy=%b out=%h expected rdy=0 out=%h",
                 k, ready_out, obs(), {1'b1, 16'h0030, 3'b000});
      end
      @(negedge clk_in);
    end
    ready_in = 1'b1;
    #1;
    n_tests++;
    if ({ready_out, obs()} !== {1'b1, 1'b1, 16'h0030, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b out=%h expected rdy=1 out=%h",
               ready_out, obs(), {1'b1, 16'h0030, 3'b000});
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    n_tests++;
    if (obs() !== {1'b1, 16'h3334, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_second: got %h expected %h", obs(), {1'b1, 16'h3334, 3'b000});
    end
    @(negedge clk_in);
    n_tests++;
    if (obs() !== {1'b1, 16'h0000, 3'b101}) begin
      n_fail++;
      $display("FAIL bp_third: got %h expected %h", obs(), {1'b1, 16'h0000, 3'b101});
    end
    @(negedge clk_in);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: valid_out %b expected 0", valid_out);
    end
  endtask

  task automatic test_reset_midflight();
    ready_in = 1'b0;
    valid_in = 1'b1; a_in = 16'h0123; b_in = 16'h0456; c_in = 1'b0;
    @(negedge clk_in);
    a_in = 16'h0F00; b_in = 16'h00F0; c_in = 1'b1;
    @(negedge clk_in);
    #1;
    n_tests++;
    if ({ready_out, valid_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_full: got rdy=%b v=%b expected rdy=0 v=1", ready_out, valid_out);
    end
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 20'h00000) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected %h", obs(), 20'h00000);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    ready_in = 1'b1;
    #1;
    n_tests++;
    if ({ready_out, valid_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_release: got rdy=%b v=%b expected rdy=1 v=0", ready_out, valid_out);
    end
    @(negedge clk_in);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale: valid_out %b expected 0", valid_out);
    end
    test_single("post_rst", 16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    test_single("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    test_single("cin",     16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
    test_single("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    test_single("all1",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    test_single("mixed",   16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    test_single("inc",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Two-stage pipelined carry-lookahead adder for the AC/E datapath.
- Stage 1 registers per-bit propagate/generate terms from the operands.
- Stage 2 resolves carries with a two-level look-ahead tree (4-bit groups plus a group-level level) and registers sum and flags.
- Valid/ready handshake on both sides; throughput of one add per cycle when not stalled.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per first-level look-ahead group; second level spans WIDTH/GROUP groups.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  asynchronous, active-low reset
- valid_in  input  1  upstream operands valid
- ready_out  output  1  adder can accept operands this cycle
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- c_in  input  1  carry in (E or increment)
- valid_out  output  1  result valid
- ready_in  input  1  downstream accepts result
- sum_out  output  WIDTH  a_in + b_in + c_in, mod 2^WIDTH
- c_out  output  1  carry out of the MSB
- ovf_out  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero_out  output  1  sum_out == 0

Behaviour:
- Reset:
  - Asynchronous on rst_n_in low; all stage registers clear.
  - Outputs while in reset: valid_out=0, sum_out=0, c_out=0, ovf_out=0, zero_out=0.
  - ready_out=1 once reset deasserts.
  - Reset mid-operation discards all in-flight transactions with no partial output.
- Stage 1 (S1):
  - On accept (valid_in && ready_out), registers p = a^b, g = a&b, and c_in.
  - Sets s1_valid=1.
- Stage 2 (S2):
  - Computes per-group carries c[i+1] = g[i] | p[i]&c[i] within each group.
  - Computes group propagate PG = AND of the group's p, and group generate GG.
  - Group carry-ins come from the second-level look-ahead over PG/GG, seeded with the S1 carry.
  - sum = p ^ carry vector.
  - Registers sum, carry out, overflow and zero, and sets valid_out.
- Latency: exactly 2 cycles from accept to valid_out when ready_in stays high.
- Handshake:
  - Output advances when !valid_out || ready_in.
  - S1 advances into S2 when s1_valid && output advances.
  - ready_out = !s1_valid || (S1 advances into S2).
  - Fully registered outputs; ready_out is combinational from ready_in (no skid buffer).
- Hold rule: while valid_out && !ready_in, sum_out and all flags hold stable, and S1 holds its contents.
- Bubbles: an S1 bubble moving forward clears valid_out only when the output slot drains.
- Simultaneous events:
  - Accept plus drain in the same cycle is allowed and sustains 1 op/cycle.
  - With both stages full and ready_in low, ready_out=0 and operands are ignored.
- Ordering: results are in strict FIFO order; no drop and no duplication.
- Width rule: carry out of bit WIDTH-1 drives c_out and is not folded into sum_out.

Test Plan:
- Reset then a=0xFFFF, b=0x0001, c_in=0 -> two cycles later sum_out=0x0000, c_out=1, ovf_out=0, zero_out=1.
- a=0x7FFF, b=0x0001, c_in=0 -> sum_out=0x8000, c_out=0, ovf_out=1, zero_out=0.
- a=0x1234, b=0x4321, c_in=1 -> sum_out=0x5556, c_out=0; then a=0x8000, b=0x8000, c_in=0 -> sum_out=0x0000, c_out=1, ovf_out=1.
- Back-to-back: 8 random pairs on consecutive cycles, ready_in=1 -> 8 consecutive valid_out cycles; each result matches the reference sum with 2-cycle latency.
- Backpressure: drive 3 ops, hold ready_in=0 for 4 cycles -> ready_out falls after 2 accepts, outputs stay stable; on release all 3 results appear in order, none lost.
- Assert rst_n_in low for 1 cycle with both stages full -> valid_out=0 immediately (asynchronous), outputs zero; after release, first new op returns correct sum 2 cycles after accept.
